// File: rtl/nn_drv_pkg.sv
// Shared definitions for the inference-core frame driver:
// FSM state encoding and default beat / class widths.
package nn_drv_pkg;

    localparam int IN_W_DEF    = 128;
    localparam int CLASSES_DEF = 10;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SEND_HI = 2'd1;
    localparam logic [1:0] ST_SEND_LO = 2'd2;
    localparam logic [1:0] ST_REPORT  = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        SEND_HI = ST_SEND_HI,
        SEND_LO = ST_SEND_LO,
        REPORT  = ST_REPORT
    } state_t;

endpackage

// File: rtl/nn_frame_driver_if.sv
// Bundle of frame handshake, core beat/result and scoreboard signals.
// master: the frame driver (drives ready, beats, results, counters).
// slave:  the environment (host frame source + inference core).
interface nn_frame_driver_if
    import nn_drv_pkg::*;
#(
    parameter int IN_W    = IN_W_DEF,
    parameter int CLASSES = CLASSES_DEF,
    parameter int CNT_W   = 16
);

    logic                 frame_valid;
    logic                 frame_ready;
    logic [2*IN_W-1:0]    frame_data;
    logic [CLASSES-1:0]   frame_label;
    logic [IN_W-1:0]      nn_in;
    logic                 nn_updown;
    logic                 nn_done;
    logic [CLASSES-1:0]   nn_out_onehot;
    logic                 res_valid;
    logic [CLASSES-1:0]   res_onehot;
    logic                 res_pass;
    logic                 res_timeout;
    logic [CNT_W-1:0]     correct_cnt;
    logic [CNT_W-1:0]     incorrect_cnt;
    logic                 clr_cnt;
    logic                 busy;

    modport master (
        input  frame_valid, frame_data, frame_label,
        input  nn_done, nn_out_onehot, clr_cnt,
        output frame_ready, nn_in, nn_updown,
        output res_valid, res_onehot, res_pass, res_timeout,
        output correct_cnt, incorrect_cnt, busy
    );

    modport slave (
        output frame_valid, frame_data, frame_label,
        output nn_done, nn_out_onehot, clr_cnt,
        input  frame_ready, nn_in, nn_updown,
        input  res_valid, res_onehot, res_pass, res_timeout,
        input  correct_cnt, incorrect_cnt, busy
    );

endinterface

// File: rtl/nn_result_scorer.sv
// Captures a core result, scores it against the label and keeps
// saturating pass/fail counters.
// In: capture_i/timeout_i/onehot_i/label_i (REPORT entry), report_i, clr_i.
// Out: res_* result registers, correct_o / incorrect_o counters.
module nn_result_scorer #(
    parameter int CLASSES = 10,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               capture_i,
    input  logic               timeout_i,
    input  logic [CLASSES-1:0] onehot_i,
    input  logic [CLASSES-1:0] label_i,
    input  logic               report_i,
    input  logic               clr_i,
    output logic               res_valid_o,
    output logic [CLASSES-1:0] res_onehot_o,
    output logic               res_pass_o,
    output logic               res_timeout_o,
    output logic [CNT_W-1:0]   correct_o,
    output logic [CNT_W-1:0]   incorrect_o
);

    logic               res_valid_q;
    logic [CLASSES-1:0] res_onehot_q;
    logic               res_pass_q;
    logic               res_timeout_q;
    logic [CNT_W-1:0]   corr_q, corr_d;
    logic [CNT_W-1:0]   inc_q, inc_d;

    // Counters bump during REPORT from the already-scored result,
    // so a clear presented in that same cycle takes priority.
    always_comb begin
        corr_d = corr_q;
        inc_d  = inc_q;
        if (clr_i) begin
            corr_d = '0;
            inc_d  = '0;
        end else if (report_i) begin
            if (res_pass_q) begin
                if (~&corr_q) corr_d = corr_q + 1'b1;
            end else begin
                if (~&inc_q) inc_d = inc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q   <= 1'b0;
            res_onehot_q  <= '0;
            res_pass_q    <= 1'b0;
            res_timeout_q <= 1'b0;
            corr_q        <= '0;
            inc_q         <= '0;
        end else begin
            res_valid_q <= capture_i;
            if (capture_i) begin
                res_onehot_q  <= onehot_i;
                res_pass_q    <= (onehot_i == label_i) & ~timeout_i;
                res_timeout_q <= timeout_i;
            end
            corr_q <= corr_d;
            inc_q  <= inc_d;
        end
    end

    assign res_valid_o   = res_valid_q;
    assign res_onehot_o  = res_onehot_q;
    assign res_pass_o    = res_pass_q;
    assign res_timeout_o = res_timeout_q;
    assign correct_o     = corr_q;
    assign incorrect_o   = inc_q;

endmodule

// File: rtl/nn_frame_driver.sv
// Two-beat frame initiator for the inference core: sends upper then
// lower half, waits for a fresh done (or timeout) and scores the result.
// Ports: clk, rst (async, active high), bus (nn_frame_driver_if.master).
module nn_frame_driver
    import nn_drv_pkg::*;
#(
    parameter int IN_W        = IN_W_DEF,
    parameter int CLASSES     = CLASSES_DEF,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    nn_frame_driver_if.master bus
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

    state_t             state_q, state_d;
    logic [2*IN_W-1:0]  frame_q, frame_d;
    logic [CLASSES-1:0] label_q, label_d;
    logic [IN_W-1:0]    nn_in_q, nn_in_d;
    logic               updown_q, updown_d;
    logic               armed_q, armed_d;
    logic [TW-1:0]      tmr_q, tmr_d;
    logic               capture;
    logic               timeout;
    logic [CLASSES-1:0] cap_onehot;

    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        label_d  = label_q;
        nn_in_d  = nn_in_q;
        updown_d = updown_q;
        armed_d  = armed_q;
        tmr_d    = tmr_q;
        capture  = 1'b0;
        timeout  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.frame_valid) begin
                    frame_d  = bus.frame_data;
                    label_d  = bus.frame_label;
                    nn_in_d  = bus.frame_data[2*IN_W-1:IN_W];
                    updown_d = 1'b0;
                    state_d  = SEND_HI;
                end
            end
            SEND_HI: begin
                nn_in_d  = frame_q[IN_W-1:0];
                updown_d = 1'b1;
                // A done still high here is left over from the
                // previous frame; arm only once it has been seen low.
                armed_d  = ~bus.nn_done;
                tmr_d    = '0;
                state_d  = SEND_LO;
            end
            SEND_LO: begin
                if (!bus.nn_done) armed_d = 1'b1;
                if (bus.nn_done && armed_q) begin
                    capture = 1'b1;
                    state_d = REPORT;
                end else if (tmr_q == T_LAST) begin
                    capture = 1'b1;
                    timeout = 1'b1;
                    state_d = REPORT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            REPORT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            frame_q  <= '0;
            label_q  <= '0;
            nn_in_q  <= '0;
            updown_q <= 1'b0;
            armed_q  <= 1'b0;
            tmr_q    <= '0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            label_q  <= label_d;
            nn_in_q  <= nn_in_d;
            updown_q <= updown_d;
            armed_q  <= armed_d;
            tmr_q    <= tmr_d;
        end
    end

    assign cap_onehot = timeout ? '0 : bus.nn_out_onehot;

    nn_result_scorer #(
        .CLASSES (CLASSES),
        .CNT_W   (CNT_W)
    ) u_scorer (
        .clk           (clk),
        .rst           (rst),
        .capture_i     (capture),
        .timeout_i     (timeout),
        .onehot_i      (cap_onehot),
        .label_i       (label_q),
        .report_i      (state_q == REPORT),
        .clr_i         (bus.clr_cnt),
        .res_valid_o   (bus.res_valid),
        .res_onehot_o  (bus.res_onehot),
        .res_pass_o    (bus.res_pass),
        .res_timeout_o (bus.res_timeout),
        .correct_o     (bus.correct_cnt),
        .incorrect_o   (bus.incorrect_cnt)
    );

    assign bus.frame_ready = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.nn_in       = nn_in_q;
    assign bus.nn_updown   = updown_q;

endmodule

// File: doc/nn_frame_driver.md
Name: nn_frame_driver

Overview:
- Hardware initiator for the inference core's two-beat input interface: accepts one 256-bit pixel frame plus an expected one-hot label over a valid/ready handshake.
- Sends the frame as an upper half (updown=0), then a lower half (updown=1). Waits for the core's done, captures the one-hot class and scores it against the label.
- Sits between an on-chip frame buffer / host port and the inference top, so an accuracy run executes entirely in hardware.

Parameters:
- IN_W, 128, width of one input beat; a frame is 2*IN_W bits.
- CLASSES, 10, width of the one-hot class vector.
- TIMEOUT_CYC, 1024, maximum SEND_LO cycles without a qualified done.
- CNT_W, 16, width of the correct/incorrect counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- frame_valid  in  1  frame offered.
- frame_ready  out  1  high only in IDLE.
- frame_data  in  2*IN_W  pixel frame; [2*IN_W-1:IN_W] is the upper half.
- frame_label  in  CLASSES  expected one-hot class.
- nn_in  out  IN_W  beat to the inference core.
- nn_updown  out  1  0 = upper half, 1 = lower half.
- nn_done  in  1  core result-valid level.
- nn_out_onehot  in  CLASSES  core one-hot result.
- res_valid  out  1  one-cycle result pulse.
- res_onehot  out  CLASSES  captured core result; 0 on timeout.
- res_pass  out  1  captured result equals label.
- res_timeout  out  1  frame aborted by timeout.
- correct_cnt  out  CNT_W  saturating pass count.
- incorrect_cnt  out  CNT_W  saturating fail-or-timeout count.
- clr_cnt  in  1  synchronous clear of both counters.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values:
  - state IDLE; nn_in=0; nn_updown=0.
  - res_valid, res_onehot, res_pass, res_timeout = 0.
  - Both counters 0; frame buffer and label registers 0.
- FSM IDLE -> SEND_HI -> SEND_LO -> REPORT -> IDLE. All outputs are registered.
- IDLE:
  - frame_ready=1; nn_in and nn_updown hold their last values.
  - On frame_valid&frame_ready at edge T, register frame_data and frame_label and go to SEND_HI.
- SEND_HI: exactly one cycle (T..T+1) with nn_updown=0 and nn_in=frame[2*IN_W-1:IN_W]. Clears the armed flag and the timeout counter.
- SEND_LO:
  - From T+1, nn_updown=1 and nn_in=frame[IN_W-1:0], held stable until the state exits.
  - armed is set on the first sampled cycle (SEND_HI or SEND_LO) where nn_done=0. This rejects a stale done left high from the previous frame.
  - Qualified done = nn_done & armed. On that edge, capture nn_out_onehot into res_onehot and go to REPORT.
  - If the timeout counter reaches TIMEOUT_CYC-1 with no qualified done, go to REPORT with res_onehot=0 and res_timeout=1.
- REPORT:
  - Exactly one cycle with res_valid=1.
  - res_pass = (captured == label) & ~timeout. Bit-exact comparison; an all-zero or multi-hot result fails.
  - Increment correct_cnt on pass, otherwise incorrect_cnt. Counters saturate at all-ones.
  - res_onehot, res_pass and res_timeout hold until the next REPORT. Next state is IDLE.
- clr_cnt:
  - Zeroes both counters at the next edge in any state.
  - If it coincides with the REPORT increment, the clear wins.
  - res_* registers are unaffected.
- Latency: accept at edge T, then the upper beat for one cycle and the lower beat from T+1. With a qualified done sampled at edge D, res_valid is high D..D+1. Minimum accept-to-accept spacing is 4 cycles.
- frame_valid while busy is ignored (ready=0); the frame is not consumed.
- Asynchronous rst mid-frame aborts immediately to reset values. No res_valid is produced and counters clear.
- nn_out_onehot is sampled only on the qualified-done edge.

Decomposition:
- Package nn_drv_pkg: FSM state encoding (IDLE, SEND_HI, SEND_LO, REPORT as 2-bit localparams) and the defaults for IN_W and CLASSES.
- Sub-module nn_result_scorer: label compare, timeout override, and the two saturating counters with clear priority.
- The top holds the FSM, frame buffer, armed flag and timeout counter.

Test Plan:
1. Pass, core done 5 cycles after updown rises.
   - Stimulus: frame_data = 256'hA5..A5 (upper) / 5A..5A (lower), label = 10'b0000001000, core returns 10'b0000001000.
   - Expect: nn_in = upper half for exactly 1 cycle with updown=0, then the lower half with updown=1. res_valid pulses once with res_pass=1. correct_cnt=1, incorrect_cnt=0.
2. Mismatch.
   - Stimulus: label = 10'b0000000001, core returns 10'b0000000010.
   - Expect: res_pass=0, res_onehot=10'b0000000010, incorrect_cnt increments by 1.
3. Stale done.
   - Stimulus: hold nn_done=1 from the previous frame through SEND_HI and 3 SEND_LO cycles, then drop it for 1 cycle, then raise it.
   - Expect: no capture until the re-rise. Exactly one res_valid.
4. Timeout.
   - Stimulus: TIMEOUT_CYC=16, nn_done stuck 0.
   - Expect: REPORT after 16 SEND_LO cycles with res_timeout=1, res_onehot=0, res_pass=0; incorrect_cnt increments by 1.
5. Reset and handshake.
   - Stimulus: assert rst mid-SEND_LO; also present frame_valid while busy, and clr_cnt coincident with REPORT.
   - Expect, reset: all outputs return to reset values with no res_valid pulse.
   - Expect, busy: frame_ready=0 and the frame is not consumed.
   - Expect, clr_cnt: both counters read 0 afterwards.
6. Saturation.
   - Stimulus: CNT_W=2; run 5 passing frames back-to-back with frame_valid held high.
   - Expect: correct_cnt=3. Accepts are spaced exactly 4 cycles apart when done returns on the first SEND_LO cycle.
